// File: rtl/pipe_ctrl_pkg.sv
// Shared widths, control-word bit positions and forwarding encodings for the
// pipeline control registers.
package pipe_ctrl_pkg;

   localparam int unsigned CTRL_W = 9;
   localparam int unsigned REG_W  = 5;

   localparam int unsigned MEMTOREG_B = 8;
   localparam int unsigned REGWRITE_B = 7;
   localparam int unsigned BRANCH_B   = 6;
   localparam int unsigned MEMREAD_B  = 5;
   localparam int unsigned MEMWRITE_B = 4;
   localparam int unsigned REGDST_B   = 3;
   localparam int unsigned ALUSRC_B   = 2;
   localparam int unsigned ALUOP_HI   = 1;
   localparam int unsigned ALUOP_LO   = 0;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

endpackage

// File: rtl/pipe_ctrl_regs_hazard_fwd_unit.sv
// Combinational load-use hazard detection and ALU operand forwarding selects.
module hazard_fwd_unit
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned REG_W = pipe_ctrl_pkg::REG_W
) (
   input  logic             idex_memread_i,
   input  logic [REG_W-1:0] idex_rt_i,
   input  logic [REG_W-1:0] id_rs_i,
   input  logic [REG_W-1:0] id_rt_i,
   input  logic             flush_i,
   input  logic [REG_W-1:0] ex_rs_i,
   input  logic [REG_W-1:0] ex_rt_i,
   input  logic             mem_regwrite_i,
   input  logic [REG_W-1:0] mem_dest_i,
   input  logic             wb_regwrite_i,
   input  logic [REG_W-1:0] wb_dest_i,
   output logic             stall_o,
   output fwd_sel_e         fwd_a_o,
   output fwd_sel_e         fwd_b_o
);

   logic haz;

   // EX/MEM writer is younger than MEM/WB, so it wins; $0 never forwards.
   function automatic fwd_sel_e pick(input logic [REG_W-1:0] src);
      if (mem_regwrite_i && (mem_dest_i != '0) && (mem_dest_i == src))
         return FWD_MEM;
      else if (wb_regwrite_i && (wb_dest_i != '0) && (wb_dest_i == src))
         return FWD_WB;
      else
         return FWD_RF;
   endfunction

   always_comb begin
      haz     = idex_memread_i && (idex_rt_i != '0) &&
                ((idex_rt_i == id_rs_i) || (idex_rt_i == id_rt_i));
      stall_o = haz && !flush_i;
      fwd_a_o = pick(ex_rs_i);
      fwd_b_o = pick(ex_rt_i);
   end

endmodule

// File: rtl/pipe_ctrl_regs.sv
// ID/EX, EX/MEM and MEM/WB control/specifier registers with EX destination
// resolution, load-use bubble insertion and forwarding selects.
module pipe_ctrl_regs
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned REG_W  = pipe_ctrl_pkg::REG_W,
   parameter int unsigned CTRL_W = pipe_ctrl_pkg::CTRL_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic [REG_W-1:0]  id_rs,
   input  logic [REG_W-1:0]  id_rt,
   input  logic [REG_W-1:0]  id_rd,
   input  logic              flush,
   output logic              stall,
   output logic              ex_regdst,
   output logic              ex_alusrc,
   output logic [1:0]        ex_aluop,
   output logic [REG_W-1:0]  ex_rs,
   output logic [REG_W-1:0]  ex_rt,
   output logic              mem_branch,
   output logic              mem_memread,
   output logic              mem_memwrite,
   output logic              mem_regwrite,
   output logic [REG_W-1:0]  mem_dest,
   output logic              wb_memtoreg,
   output logic              wb_regwrite,
   output logic [REG_W-1:0]  wb_dest,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b
);

   logic [CTRL_W-1:0] idex_ctrl_q, idex_ctrl_d;
   logic [REG_W-1:0]  idex_rs_q, idex_rs_d;
   logic [REG_W-1:0]  idex_rt_q, idex_rt_d;
   logic [REG_W-1:0]  idex_rd_q, idex_rd_d;
   logic [1:0]        exmem_wb_q, exmem_wb_d;
   logic [2:0]        exmem_m_q, exmem_m_d;
   logic [REG_W-1:0]  exmem_dest_q, exmem_dest_d;
   logic [1:0]        memwb_wb_q, memwb_wb_d;
   logic [REG_W-1:0]  memwb_dest_q, memwb_dest_d;
   logic [REG_W-1:0]  ex_dest;
   fwd_sel_e          fwd_a_sel, fwd_b_sel;

   hazard_fwd_unit #(.REG_W(REG_W)) u_hazard_fwd (
      .idex_memread_i (idex_ctrl_q[MEMREAD_B]),
      .idex_rt_i      (idex_rt_q),
      .id_rs_i        (id_rs),
      .id_rt_i        (id_rt),
      .flush_i        (flush),
      .ex_rs_i        (idex_rs_q),
      .ex_rt_i        (idex_rt_q),
      .mem_regwrite_i (exmem_wb_q[0]),
      .mem_dest_i     (exmem_dest_q),
      .wb_regwrite_i  (memwb_wb_q[0]),
      .wb_dest_i      (memwb_dest_q),
      .stall_o        (stall),
      .fwd_a_o        (fwd_a_sel),
      .fwd_b_o        (fwd_b_sel)
   );

   // flush | haz reduces to flush | stall, so the bubble needs no raw haz.
   always_comb begin
      ex_dest = idex_ctrl_q[REGDST_B] ? idex_rd_q : idex_rt_q;

      idex_ctrl_d = id_ctrl;
      idex_rs_d   = id_rs;
      idex_rt_d   = id_rt;
      idex_rd_d   = id_rd;
      if (flush || stall) begin
         idex_ctrl_d = '0;
         idex_rs_d   = '0;
         idex_rt_d   = '0;
         idex_rd_d   = '0;
      end

      exmem_wb_d   = {idex_ctrl_q[MEMTOREG_B], idex_ctrl_q[REGWRITE_B]};
      exmem_m_d    = {idex_ctrl_q[BRANCH_B], idex_ctrl_q[MEMREAD_B], idex_ctrl_q[MEMWRITE_B]};
      exmem_dest_d = ex_dest;
      if (flush) begin
         exmem_wb_d   = '0;
         exmem_m_d    = '0;
         exmem_dest_d = '0;
      end

      memwb_wb_d   = exmem_wb_q;
      memwb_dest_d = exmem_dest_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idex_ctrl_q  <= '0;
         idex_rs_q    <= '0;
         idex_rt_q    <= '0;
         idex_rd_q    <= '0;
         exmem_wb_q   <= '0;
         exmem_m_q    <= '0;
         exmem_dest_q <= '0;
         memwb_wb_q   <= '0;
         memwb_dest_q <= '0;
      end else begin
         idex_ctrl_q  <= idex_ctrl_d;
         idex_rs_q    <= idex_rs_d;
         idex_rt_q    <= idex_rt_d;
         idex_rd_q    <= idex_rd_d;
         exmem_wb_q   <= exmem_wb_d;
         exmem_m_q    <= exmem_m_d;
         exmem_dest_q <= exmem_dest_d;
         memwb_wb_q   <= memwb_wb_d;
         memwb_dest_q <= memwb_dest_d;
      end
   end

   assign ex_regdst    = idex_ctrl_q[REGDST_B];
   assign ex_alusrc    = idex_ctrl_q[ALUSRC_B];
   assign ex_aluop     = idex_ctrl_q[ALUOP_HI:ALUOP_LO];
   assign ex_rs        = idex_rs_q;
   assign ex_rt        = idex_rt_q;
   assign mem_branch   = exmem_m_q[2];
   assign mem_memread  = exmem_m_q[1];
   assign mem_memwrite = exmem_m_q[0];
   assign mem_regwrite = exmem_wb_q[0];
   assign mem_dest     = exmem_dest_q;
   assign wb_memtoreg  = memwb_wb_q[1];
   assign wb_regwrite  = memwb_wb_q[0];
   assign wb_dest      = memwb_dest_q;
   assign fwd_a        = fwd_a_sel;
   assign fwd_b        = fwd_b_sel;

endmodule
